// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vram_arbiter
//  Purpose  : Shares one single-port synchronous frame-buffer RAM between the
//             pixel scan-out read path and a posted-write requester. Display
//             reads always win. Writes are queued in a small FIFO and drained
//             only in cycles without a display read, and, unless WR_IN_ACTIVE
//             is set, only while the horizontal timing is outside the active
//             region.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK         in   system / pixel clock, rising edge
//    RESETN      in   asynchronous active-low reset
//    HSTATE      in   horizontal FSM state (0 sync, 1 bp, 2 active, 3 fp)
//    disp_req    in   display read request, one per pixel
//    disp_addr   in   display read address
//    disp_valid  out  read data valid, one-cycle pulse
//    disp_data   out  read data
//    wr_valid    in   posted write request
//    wr_addr     in   write address
//    wr_data     in   write data
//    wr_ready    out  FIFO can accept a write this cycle
//    fifo_level  out  current FIFO occupancy
//    mem_addr    out  registered RAM address
//    mem_wdata   out  registered RAM write data
//    mem_we      out  registered RAM write enable
//    mem_re      out  registered RAM read enable
//    mem_rdata   in   RAM read data, one cycle after mem_re is sampled
// ============================================================================
module vram_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,   // power of two, >= 2
    parameter int WR_IN_ACTIVE = 0
) (
    input  logic                            CLK,
    input  logic                            RESETN,
    input  logic [1:0]                      HSTATE,
    input  logic                            disp_req,
    input  logic [ADDR_W-1:0]               disp_addr,
    output logic                            disp_valid,
    output logic [DATA_W-1:0]               disp_data,
    input  logic                            wr_valid,
    input  logic [ADDR_W-1:0]               wr_addr,
    input  logic [DATA_W-1:0]               wr_data,
    output logic                            wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_wdata,
    output logic                            mem_we,
    output logic                            mem_re,
    input  logic [DATA_W-1:0]               mem_rdata
);

    localparam int         c_ptr_w     = $clog2(FIFO_DEPTH);
    localparam int         c_lvl_w     = c_ptr_w + 1;
    localparam logic [1:0] c_hs_active = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DISP = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Posted-write FIFO
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0]  r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]  r_fifo_data [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0] r_level;

    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_drain_ok;
    logic               w_push;
    logic               w_pop;
    logic [ADDR_W-1:0]  w_head_addr;
    logic [DATA_W-1:0]  w_head_data;

    assign w_fifo_full  = (r_level == c_lvl_w'(FIFO_DEPTH));
    assign w_fifo_empty = (r_level == '0);

    // Acceptance uses pre-edge occupancy, so a pop at the same edge does not
    // open a slot for a write arriving at that edge.
    assign wr_ready     = RESETN && !w_fifo_full;
    assign w_push       = wr_valid && wr_ready;

    // Drain only when the display path leaves the RAM free and the
    // horizontal timing permits writes.
    assign w_drain_ok   = (HSTATE != c_hs_active) || (WR_IN_ACTIVE != 0);
    assign w_pop        = !disp_req && !w_fifo_empty && w_drain_ok;

    assign w_head_addr  = r_fifo_addr[r_rd_ptr];
    assign w_head_data  = r_fifo_data[r_rd_ptr];
    assign fifo_level   = r_level;

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= wr_addr;
            r_fifo_data[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lvl_w'(1);
                2'b01:   r_level <= r_level - c_lvl_w'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Arbiter FSM with registered RAM controls and display read return path
    // ------------------------------------------------------------------------
    state_t r_state;
    logic   r_rd_pend;   // RAM sampled a read at the last edge; data arrives now

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state    <= ST_IDLE;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            r_rd_pend  <= 1'b0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
        end else begin
            if (disp_req) begin
                r_state  <= ST_DISP;
                mem_addr <= disp_addr;
                mem_re   <= 1'b1;
                mem_we   <= 1'b0;
            end else if (w_pop) begin
                r_state   <= ST_WR;
                mem_addr  <= w_head_addr;
                mem_wdata <= w_head_data;
                mem_we    <= 1'b1;
                mem_re    <= 1'b0;
            end else begin
                // Address and data hold to avoid needless RAM bus toggling.
                r_state <= ST_IDLE;
                mem_we  <= 1'b0;
                mem_re  <= 1'b0;
            end

            // Two-edge read latency: request issued -> RAM samples -> capture.
            r_rd_pend  <= (r_state == ST_DISP);
            disp_valid <= r_rd_pend;
            if (r_rd_pend) begin
                disp_data <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vram_arbiter
//  Purpose  : Directed self-checking bench for vram_arbiter with a behavioural
//             single-port RAM whose initial contents are the low byte of the
//             address.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic               CLK = 1'b0;
    logic               RESETN;
    logic [1:0]         HSTATE;
    logic               disp_req;
    logic [ADDR_W-1:0]  disp_addr;
    logic               disp_valid;
    logic [DATA_W-1:0]  disp_data;
    logic               wr_valid;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic               wr_ready;
    logic [2:0]         fifo_level;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic               mem_we;
    logic               mem_re;
    logic [DATA_W-1:0]  mem_rdata = '0;

    logic [DATA_W-1:0]  ram [0:65535];

    int n_tests = 0;
    int n_fail  = 0;

    vram_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .FIFO_DEPTH   (DEPTH),
        .WR_IN_ACTIVE (0)
    ) dut (
        .CLK        (CLK),
        .RESETN     (RESETN),
        .HSTATE     (HSTATE),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .fifo_level (fifo_level),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata)
    );

    always #5 CLK = ~CLK;

    // Synchronous single-port RAM: read data appears one cycle after mem_re.
    always @(posedge CLK) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) ram[a] = a[7:0];

        RESETN    = 1'b1;
        HSTATE    = 2'd0;
        disp_req  = 1'b0;
        disp_addr = '0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;

        // ---------------- Reset and idle ----------------
        #2 RESETN = 1'b0;
        repeat (3) tick();
        chk("rst_mem_we",     mem_we,     0);
        chk("rst_mem_re",     mem_re,     0);
        chk("rst_mem_addr",   mem_addr,   0);
        chk("rst_mem_wdata",  mem_wdata,  0);
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_disp_data",  disp_data,  0);
        chk("rst_wr_ready",   wr_ready,   0);
        chk("rst_level",      fifo_level, 0);
        RESETN = 1'b1;
        #1;
        chk("rel_wr_ready", wr_ready,   1);
        chk("rel_level",    fifo_level, 0);
        tick();
        chk("idle_we", mem_we, 0);
        chk("idle_re", mem_re, 0);

        // ---------------- Read latency ----------------
        HSTATE    = 2'd2;
        disp_req  = 1'b1;
        disp_addr = 16'h0010;
        tick();                                   // E0
        chk("rd_e0_re",    mem_re,     1);
        chk("rd_e0_addr",  mem_addr,   16'h0010);
        chk("rd_e0_valid", disp_valid, 0);
        disp_addr = 16'h0011;
        tick();                                   // E1
        chk("rd_e1_addr",  mem_addr,   16'h0011);
        chk("rd_e1_valid", disp_valid, 0);
        disp_addr = 16'h0012;
        tick();                                   // E2
        chk("rd_e2_valid", disp_valid, 1);
        chk("rd_e2_data",  disp_data,  8'h10);
        disp_addr = 16'h0013;
        tick();
        chk("rd_e3_valid", disp_valid, 1);
        chk("rd_e3_data",  disp_data,  8'h11);
        disp_req = 1'b0;
        tick();
        chk("rd_e4_re",    mem_re,     0);
        chk("rd_e4_valid", disp_valid, 1);
        chk("rd_e4_data",  disp_data,  8'h12);
        tick();
        chk("rd_e5_valid", disp_valid, 1);
        chk("rd_e5_data",  disp_data,  8'h13);
        tick();
        chk("rd_e6_valid", disp_valid, 0);

        // ---------------- Blocked drain in active region ----------------
        wr_valid = 1'b1; wr_addr = 16'h0100; wr_data = 8'hAA;
        tick();
        chk("blk_lvl1", fifo_level, 1);
        chk("blk_we1",  mem_we,     0);
        wr_addr = 16'h0101; wr_data = 8'hBB;
        tick();
        chk("blk_lvl2", fifo_level, 2);
        chk("blk_we2",  mem_we,     0);
        wr_valid = 1'b0;
        tick();
        chk("blk_lvl_hold", fifo_level, 2);
        chk("blk_we_hold",  mem_we,     0);
        HSTATE = 2'd3;
        tick();
        chk("drn0_we",    mem_we,     1);
        chk("drn0_addr",  mem_addr,   16'h0100);
        chk("drn0_data",  mem_wdata,  8'hAA);
        chk("drn0_lvl",   fifo_level, 1);
        tick();
        chk("drn1_we",    mem_we,     1);
        chk("drn1_addr",  mem_addr,   16'h0101);
        chk("drn1_data",  mem_wdata,  8'hBB);
        chk("drn1_lvl",   fifo_level, 0);
        tick();
        chk("drn_done_we", mem_we, 0);
        chk("ram_0100",    ram[16'h0100], 8'hAA);
        chk("ram_0101",    ram[16'h0101], 8'hBB);

        // ---------------- Full FIFO ----------------
        HSTATE = 2'd2;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 16'h0200 + 16'(i);
            wr_data  = 8'h30 + 8'(i);
            chk("full_rdy", wr_ready, 1);
            tick();
            chk("full_lvl", fifo_level, 32'(i + 1));
        end
        wr_addr = 16'h0204; wr_data = 8'h34;
        chk("full_rdy5", wr_ready, 0);
        tick();
        chk("full_lvl5", fifo_level, 4);
        chk("full_we5",  mem_we,     0);
        tick();
        chk("full_pend", fifo_level, 4);
        HSTATE = 2'd0;
        tick();                                   // first pop, no push
        chk("full_pop0_we",   mem_we,     1);
        chk("full_pop0_addr", mem_addr,   16'h0200);
        chk("full_pop0_lvl",  fifo_level, 3);
        chk("full_rdy_after", wr_ready,   1);
        tick();                                   // push of 5th + pop
        chk("full_pp_addr", mem_addr,   16'h0201);
        chk("full_pp_data", mem_wdata,  8'h31);
        chk("full_pp_lvl",  fifo_level, 3);
        wr_valid = 1'b0;
        for (int j = 2; j < 5; j++) begin
            tick();
            chk("full_drn_we",   mem_we,     1);
            chk("full_drn_addr", mem_addr,   32'(16'h0200 + 16'(j)));
            chk("full_drn_data", mem_wdata,  32'(8'h30 + 8'(j)));
            chk("full_drn_lvl",  fifo_level, 32'(4 - j));
        end
        tick();
        chk("full_done_we", mem_we, 0);

        // ---------------- Display priority in blanking ----------------
        HSTATE = 2'd2;
        wr_valid = 1'b1; wr_addr = 16'h0300; wr_data = 8'hC0;
        tick();
        wr_addr = 16'h0301; wr_data = 8'hC1;
        tick();
        wr_valid = 1'b0;
        chk("pri_lvl2", fifo_level, 2);
        HSTATE = 2'd0;
        disp_req = 1'b1; disp_addr = 16'h0020;
        tick();
        chk("pri_a_re",  mem_re,     1);
        chk("pri_a_we",  mem_we,     0);
        chk("pri_a_lvl", fifo_level, 2);
        disp_req = 1'b0;
        tick();
        chk("pri_b_we",   mem_we,     1);
        chk("pri_b_re",   mem_re,     0);
        chk("pri_b_addr", mem_addr,   16'h0300);
        chk("pri_b_lvl",  fifo_level, 1);
        disp_req = 1'b1; disp_addr = 16'h0021;
        tick();
        chk("pri_c_re",    mem_re,     1);
        chk("pri_c_we",    mem_we,     0);
        chk("pri_c_valid", disp_valid, 1);
        chk("pri_c_data",  disp_data,  8'h20);
        disp_req = 1'b0;
        tick();
        chk("pri_d_we",    mem_we,     1);
        chk("pri_d_excl",  mem_re,     0);
        chk("pri_d_data",  mem_wdata,  8'hC1);
        chk("pri_d_lvl",   fifo_level, 0);
        chk("pri_d_valid", disp_valid, 0);
        tick();
        chk("pri_e_valid", disp_valid, 1);
        chk("pri_e_data",  disp_data,  8'h21);
        chk("pri_e_we",    mem_we,     0);

        // ---------------- Mid-operation reset ----------------
        HSTATE = 2'd2;
        for (int k = 0; k < 3; k++) begin
            wr_valid = 1'b1;
            wr_addr  = 16'h0400 + 16'(k);
            wr_data  = 8'hD0 + 8'(k);
            tick();
        end
        wr_valid = 1'b0;
        chk("mr_lvl3", fifo_level, 3);
        disp_req = 1'b1; disp_addr = 16'h0030;
        tick();
        chk("mr_re", mem_re, 1);
        disp_req = 1'b0;
        RESETN = 1'b0;
        #1;
        chk("mr_lvl0",  fifo_level, 0);
        chk("mr_re0",   mem_re,     0);
        chk("mr_we0",   mem_we,     0);
        chk("mr_rdy0",  wr_ready,   0);
        @(negedge CLK);
        RESETN = 1'b1;
        HSTATE = 2'd3;
        for (int m = 0; m < 4; m++) begin
            tick();
            chk("mr_no_valid", disp_valid, 0);
            chk("mr_no_we",    mem_we,     0);
            chk("mr_lvl",      fifo_level, 0);
        end
        chk("mr_ram_0400", ram[16'h0400], 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
